// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-PC stage and its branch target buffer.
// Entry fields are sized for the widest supported PC (64 bits); narrower builds zero-extend.
package pc_pkg;

    localparam int PC_MAX_W = 64;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'd0;
    localparam ctr_t CTR_WNT = 2'd1;
    localparam ctr_t CTR_WT  = 2'd2;
    localparam ctr_t CTR_ST  = 2'd3;

    typedef struct packed {
        logic                valid;
        logic [PC_MAX_W-1:0] tag;
        logic [PC_MAX_W-1:0] target;
        ctr_t                ctr;
    } btb_entry_t;

    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        ctr_t nxt;
        if (taken) begin
            nxt = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end else begin
            nxt = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btb_direct_mapped.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC and
// single-entry training from execute. Ports carry word addresses (PC >> 2).
module btb_direct_mapped
    import pc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BTB_DEPTH = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-3:0] lookup_word_i,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            train_en_i,
    input  logic [XLEN-3:0] train_word_i,
    input  logic            train_is_jump_i,
    input  logic            train_taken_i,
    input  logic [XLEN-1:0] train_target_i
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = XLEN - IDX_W - 2;

    btb_entry_t btb_q [BTB_DEPTH];

    logic [IDX_W-1:0] lk_idx_s;
    logic [TAG_W-1:0] lk_tag_s;
    logic [IDX_W-1:0] tr_idx_s;
    logic [TAG_W-1:0] tr_tag_s;
    btb_entry_t       tr_cur_s;
    btb_entry_t       tr_entry_d;
    logic             tr_hit_s;

    assign lk_idx_s = lookup_word_i[IDX_W-1:0];
    assign lk_tag_s = lookup_word_i[XLEN-3:IDX_W];
    assign tr_idx_s = train_word_i[IDX_W-1:0];
    assign tr_tag_s = train_word_i[XLEN-3:IDX_W];

    // Lookup reads the stored entry directly, so a same-cycle update is seen only next cycle.
    assign pred_taken_o  = btb_q[lk_idx_s].valid
                        && (btb_q[lk_idx_s].tag == PC_MAX_W'(lk_tag_s))
                        && (btb_q[lk_idx_s].ctr >= CTR_WT);
    assign pred_target_o = btb_q[lk_idx_s].target[XLEN-1:0];

    assign tr_cur_s = btb_q[tr_idx_s];
    assign tr_hit_s = tr_cur_s.valid && (tr_cur_s.tag == PC_MAX_W'(tr_tag_s));

    // Next value of the trained entry: update on hit, allocate on a taken miss.
    always_comb begin
        tr_entry_d = tr_cur_s;
        if (tr_hit_s) begin
            if (train_is_jump_i) begin
                tr_entry_d.ctr    = CTR_ST;
                tr_entry_d.target = PC_MAX_W'(train_target_i);
            end else begin
                tr_entry_d.ctr = sat_update(tr_cur_s.ctr, train_taken_i);
                if (train_taken_i) begin
                    tr_entry_d.target = PC_MAX_W'(train_target_i);
                end else begin
                    tr_entry_d.target = tr_cur_s.target;
                end
            end
        end else if (train_taken_i) begin
            tr_entry_d.valid  = 1'b1;
            tr_entry_d.tag    = PC_MAX_W'(tr_tag_s);
            tr_entry_d.target = PC_MAX_W'(train_target_i);
            tr_entry_d.ctr    = train_is_jump_i ? CTR_ST : CTR_WT;
        end else begin
            tr_entry_d = tr_cur_s;
        end
    end

    // Entry storage; reset invalidates everything and zeroes the counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_q[i] <= '0;
            end
        end else if (train_en_i) begin
            btb_q[tr_idx_s] <= tr_entry_d;
        end
    end

endmodule

// File: rtl/program_counter_stage_v2.sv
// Fetch-PC register with BTB-based next-PC prediction and execute-stage redirect.
// Optional PC_STATS_EN adds saturating resolved/mispredict counters.
module program_counter_stage_v2
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
    parameter int              BTB_DEPTH    = 16
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            STALL,
    input  logic            EX_VALID,
    input  logic            EX_IS_BRANCH,
    input  logic            EX_IS_JUMP,
    input  logic            EX_TAKEN,
    input  logic [XLEN-1:0] EX_PC,
    input  logic [XLEN-1:0] EX_TARGET,
    input  logic [XLEN-1:0] EX_PRED_NEXT_PC,
    output logic [XLEN-1:0] PC,
    output logic            PC_VALID,
    output logic [XLEN-1:0] PRED_NEXT_PC,
    output logic            PRED_TAKEN,
    output logic            FLUSH_IF,
    output logic            FLUSH_ID
`ifdef PC_STATS_EN
    ,
    output logic [31:0]     STAT_RESOLVED,
    output logic [31:0]     STAT_MISPREDICT
`endif
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            pc_valid_q;
    logic            btb_taken_s;
    logic [XLEN-1:0] btb_target_s;
    logic [XLEN-1:0] pred_next_s;
    logic            ex_taken_s;
    logic [XLEN-1:0] actual_s;
    logic            redirect_s;
    logic            train_en_s;

    btb_direct_mapped #(
        .XLEN      (XLEN),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk_i           (CLK),
        .rst_ni          (RST_N),
        .lookup_word_i   (pc_q[XLEN-1:2]),
        .pred_taken_o    (btb_taken_s),
        .pred_target_o   (btb_target_s),
        .train_en_i      (train_en_s),
        .train_word_i    (EX_PC[XLEN-1:2]),
        .train_is_jump_i (EX_IS_JUMP),
        .train_taken_i   (ex_taken_s),
        .train_target_i  (EX_TARGET)
    );

    assign pred_next_s = btb_taken_s ? btb_target_s : pc_q + XLEN'(32'd4);
    assign ex_taken_s  = EX_IS_JUMP || (EX_IS_BRANCH && EX_TAKEN);
    assign actual_s    = ex_taken_s ? EX_TARGET : EX_PC + XLEN'(32'd4);
    assign redirect_s  = EX_VALID && (actual_s != EX_PRED_NEXT_PC);
    assign train_en_s  = EX_VALID && (EX_IS_BRANCH || EX_IS_JUMP);

    // Next fetch address: redirect beats stall; the first edge out of reset only arms PC_VALID.
    always_comb begin
        pc_d = pc_q;
        if (redirect_s) begin
            pc_d = actual_s;
        end else if (STALL || !pc_valid_q) begin
            pc_d = pc_q;
        end else begin
            pc_d = pred_next_s;
        end
    end

    // PC and fetch-valid registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= 1'b1;
        end
    end

    assign PC           = pc_q;
    assign PC_VALID     = pc_valid_q;
    assign PRED_NEXT_PC = pred_next_s;
    assign PRED_TAKEN   = btb_taken_s;
    assign FLUSH_IF     = redirect_s;
    assign FLUSH_ID     = redirect_s;

`ifdef PC_STATS_EN
    logic [31:0] stat_res_q;
    logic [31:0] stat_mis_q;

    // Saturating event counters for resolved control flow and redirects.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stat_res_q <= 32'd0;
            stat_mis_q <= 32'd0;
        end else begin
            if (train_en_s && (stat_res_q != 32'hFFFF_FFFF)) begin
                stat_res_q <= stat_res_q + 32'd1;
            end
            if (redirect_s && (stat_mis_q != 32'hFFFF_FFFF)) begin
                stat_mis_q <= stat_mis_q + 32'd1;
            end
        end
    end

    assign STAT_RESOLVED   = stat_res_q;
    assign STAT_MISPREDICT = stat_mis_q;
`endif

endmodule

// File: tb/tb_program_counter_stage_v2.sv
// Scoreboard bench for program_counter_stage_v2 (RESET_VECTOR 0x100, two-entry BTB).
// Expected per-cycle outputs are queued as each cycle is driven and compared once it settles.
module tb_program_counter_stage_v2;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        STALL;
    logic        EX_VALID;
    logic        EX_IS_BRANCH;
    logic        EX_IS_JUMP;
    logic        EX_TAKEN;
    logic [31:0] EX_PC;
    logic [31:0] EX_TARGET;
    logic [31:0] EX_PRED_NEXT_PC;
    logic [31:0] PC;
    logic        PC_VALID;
    logic [31:0] PRED_NEXT_PC;
    logic        PRED_TAKEN;
    logic        FLUSH_IF;
    logic        FLUSH_ID;
`ifdef PC_STATS_EN
    logic [31:0] STAT_RESOLVED;
    logic [31:0] STAT_MISPREDICT;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_res  = 0;
    int exp_mis  = 0;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       tag;
    } sb_item_t;

    sb_item_t sb_q[$];

    always #5 CLK = ~CLK;

    program_counter_stage_v2 #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0100),
        .BTB_DEPTH    (2)
    ) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .STALL           (STALL),
        .EX_VALID        (EX_VALID),
        .EX_IS_BRANCH    (EX_IS_BRANCH),
        .EX_IS_JUMP      (EX_IS_JUMP),
        .EX_TAKEN        (EX_TAKEN),
        .EX_PC           (EX_PC),
        .EX_TARGET       (EX_TARGET),
        .EX_PRED_NEXT_PC (EX_PRED_NEXT_PC),
        .PC              (PC),
        .PC_VALID        (PC_VALID),
        .PRED_NEXT_PC    (PRED_NEXT_PC),
        .PRED_TAKEN      (PRED_TAKEN),
        .FLUSH_IF        (FLUSH_IF),
        .FLUSH_ID        (FLUSH_ID)
`ifdef PC_STATS_EN
        ,
        .STAT_RESOLVED   (STAT_RESOLVED),
        .STAT_MISPREDICT (STAT_MISPREDICT)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return PC;
            1:       return {31'd0, PC_VALID};
            2:       return PRED_NEXT_PC;
            3:       return {31'd0, PRED_TAKEN};
            4:       return {31'd0, FLUSH_IF};
            5:       return {31'd0, FLUSH_ID};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push_one(input int sel, input logic [31:0] exp, input string tag);
        sb_item_t it;
        it.sel = sel;
        it.exp = exp;
        it.tag = tag;
        sb_q.push_back(it);
    endtask

    task automatic push_exp(input string nm, input logic [31:0] pc, input logic pv,
                            input logic [31:0] pn, input logic pt, input logic fl);
        push_one(0, pc, {nm, ".pc"});
        push_one(1, {31'd0, pv}, {nm, ".pc_valid"});
        push_one(2, pn, {nm, ".pred_next"});
        push_one(3, {31'd0, pt}, {nm, ".pred_taken"});
        push_one(4, {31'd0, fl}, {nm, ".flush_if"});
        push_one(5, {31'd0, fl}, {nm, ".flush_id"});
    endtask

    task automatic drain();
        sb_item_t it;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check(it.tag, observe(it.sel), it.exp);
        end
    endtask

    // ex = {valid, is_branch, is_jump}
    task automatic cyc(input string nm, input logic stall, input logic [2:0] ex, input logic tk,
                       input logic [31:0] epc, input logic [31:0] etgt, input logic [31:0] epred,
                       input logic [31:0] xpc, input logic [31:0] xpn, input logic xpt, input logic xfl);
        @(negedge CLK);
        STALL           = stall;
        EX_VALID        = ex[2];
        EX_IS_BRANCH    = ex[1];
        EX_IS_JUMP      = ex[0];
        EX_TAKEN        = tk;
        EX_PC           = epc;
        EX_TARGET       = etgt;
        EX_PRED_NEXT_PC = epred;
        push_exp(nm, xpc, 1'b1, xpn, xpt, xfl);
        if (ex[2] && (ex[1] || ex[0])) exp_res++;
        if (xfl) exp_mis++;
        #1;
        drain();
    endtask

    task automatic check_stats(input string nm, input int r, input int m);
`ifdef PC_STATS_EN
        check({nm, ".stat_resolved"}, STAT_RESOLVED, 32'(r));
        check({nm, ".stat_mispredict"}, STAT_MISPREDICT, 32'(m));
`else
        if (r < 0 || m < 0) $display("negative stat expectation in %s", nm);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_N = 1'b0; STALL = 1'b0; EX_VALID = 1'b0; EX_IS_BRANCH = 1'b0; EX_IS_JUMP = 1'b0;
        EX_TAKEN = 1'b0; EX_PC = 32'd0; EX_TARGET = 32'd0; EX_PRED_NEXT_PC = 32'd0;
        repeat (2) @(negedge CLK);
        #1;
        push_exp("rst", 32'h100, 1'b0, 32'h104, 1'b0, 1'b0);
        drain();
        check_stats("rst", 0, 0);
        RST_N = 1'b1;

        //   name stall ex      tk    ex_pc         ex_tgt        ex_pred       pc            pred_next     pt    flush
        cyc("A", 1'b0, 3'b000, 1'b0, 32'h0,        32'h0,        32'h0,        32'h100,      32'h104,      1'b0, 1'b0);
        cyc("B", 1'b0, 3'b000, 1'b0, 32'h0,        32'h0,        32'h0,        32'h104,      32'h108,      1'b0, 1'b0);
        cyc("C", 1'b0, 3'b110, 1'b1, 32'h108,      32'h200,      32'h10C,      32'h108,      32'h10C,      1'b0, 1'b1);
        cyc("D", 1'b0, 3'b100, 1'b0, 32'h104,      32'h0,        32'h300,      32'h200,      32'h204,      1'b0, 1'b1);
        cyc("E", 1'b0, 3'b110, 1'b0, 32'h108,      32'h200,      32'h200,      32'h108,      32'h200,      1'b1, 1'b1);
        cyc("F", 1'b0, 3'b100, 1'b0, 32'h104,      32'h0,        32'h300,      32'h10C,      32'h110,      1'b0, 1'b1);
        cyc("G", 1'b0, 3'b110, 1'b0, 32'h108,      32'h200,      32'h10C,      32'h108,      32'h10C,      1'b0, 1'b0);
        cyc("H", 1'b0, 3'b110, 1'b1, 32'h108,      32'h200,      32'h10C,      32'h10C,      32'h110,      1'b0, 1'b1);
        cyc("I", 1'b0, 3'b100, 1'b0, 32'h104,      32'h0,        32'h300,      32'h200,      32'h204,      1'b0, 1'b1);
        cyc("J", 1'b0, 3'b000, 1'b0, 32'h0,        32'h0,        32'h0,        32'h108,      32'h10C,      1'b0, 1'b0);
        cyc("K", 1'b1, 3'b000, 1'b0, 32'h0,        32'h0,        32'h0,        32'h10C,      32'h110,      1'b0, 1'b0);
        cyc("L", 1'b1, 3'b000, 1'b0, 32'h0,        32'h0,        32'h0,        32'h10C,      32'h110,      1'b0, 1'b0);
        cyc("M", 1'b1, 3'b000, 1'b0, 32'h0,        32'h0,        32'h0,        32'h10C,      32'h110,      1'b0, 1'b0);
        cyc("N", 1'b1, 3'b100, 1'b0, 32'h2FC,      32'h0,        32'h0,        32'h10C,      32'h110,      1'b0, 1'b1);
        cyc("O", 1'b0, 3'b100, 1'b0, 32'hFFFFFFF8, 32'h0,        32'h0,        32'h300,      32'h304,      1'b0, 1'b1);
        cyc("P", 1'b0, 3'b000, 1'b0, 32'h0,        32'h0,        32'h0,        32'hFFFFFFFC, 32'h0,        1'b0, 1'b0);
        cyc("Q", 1'b0, 3'b101, 1'b0, 32'h40,       32'h80,       32'h44,       32'h0,        32'h4,        1'b0, 1'b1);
        cyc("R", 1'b0, 3'b100, 1'b0, 32'h3C,       32'h0,        32'h0,        32'h80,       32'h84,       1'b0, 1'b1);
        cyc("S", 1'b0, 3'b110, 1'b1, 32'h48,       32'hC0,       32'h4C,       32'h40,       32'h80,       1'b1, 1'b1);
        cyc("T", 1'b0, 3'b100, 1'b0, 32'h3C,       32'h0,        32'h0,        32'hC0,       32'hC4,       1'b0, 1'b1);
        cyc("U", 1'b0, 3'b000, 1'b0, 32'h0,        32'h0,        32'h0,        32'h40,       32'h44,       1'b0, 1'b0);
        cyc("V", 1'b0, 3'b000, 1'b0, 32'h0,        32'h0,        32'h0,        32'h44,       32'h48,       1'b0, 1'b0);
        cyc("W", 1'b0, 3'b000, 1'b0, 32'h0,        32'h0,        32'h0,        32'h48,       32'hC0,       1'b1, 1'b0);

        @(negedge CLK);
        #1;
        check_stats("run", exp_res, exp_mis);

        // Redirect pending when reset hits must be discarded.
        cyc("X", 1'b0, 3'b100, 1'b0, 32'h3C,       32'h0,        32'h0,        32'hC4,       32'hC8,       1'b0, 1'b1);
        RST_N    = 1'b0;
        EX_VALID = 1'b0;
        #1;
        push_exp("midrst", 32'h100, 1'b0, 32'h104, 1'b0, 1'b0);
        drain();
        check_stats("midrst", 0, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        cyc("Y", 1'b0, 3'b100, 1'b0, 32'h44,       32'h0,        32'h0,        32'h100,      32'h104,      1'b0, 1'b1);
        cyc("Z", 1'b0, 3'b000, 1'b0, 32'h0,        32'h0,        32'h0,        32'h48,       32'h4C,       1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/program_counter_stage_v2.md
# program_counter_stage_v2

Parametrised fetch-address generator at the head of the pipeline. It holds the architectural fetch PC and predicts the next PC with a direct-mapped branch target buffer (BTB) carrying 2-bit saturating counters. Execute-stage resolutions train the BTB and repair mispredictions. It drives the instruction-fetch address, the predicted successor PC that travels down the pipeline, and the flush requests for the fetch and decoding stages.

## Interface
Parameters:
- XLEN, 32, PC/target width.
- RESET_VECTOR, 32'h0, PC value held during and after reset.
- BTB_DEPTH, 16, BTB entries; power of two, at least 2.
- IDX_W, $clog2(BTB_DEPTH), index width (derived, not overridden).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- STALL  in  1  hold the PC (fetch back-pressure).
- EX_VALID  in  1  execute stage holds a valid instruction this cycle.
- EX_IS_BRANCH  in  1  conditional branch in execute.
- EX_IS_JUMP  in  1  JAL/JALR in execute.
- EX_TAKEN  in  1  resolved direction; ignored unless branch; jumps are always taken.
- EX_PC  in  XLEN  PC of the execute instruction.
- EX_TARGET  in  XLEN  resolved target (rs1/PC + imm, computed in execute).
- EX_PRED_NEXT_PC  in  XLEN  PRED_NEXT_PC value carried with that instruction.
- PC  out  XLEN  current fetch address.
- PC_VALID  out  1  PC is a live fetch request.
- PRED_NEXT_PC  out  XLEN  predicted successor of PC; carried down the pipe.
- PRED_TAKEN  out  1  PRED_NEXT_PC came from the BTB.
- FLUSH_IF  out  1  kill the instruction in fetch.
- FLUSH_ID  out  1  kill the instruction in decode.

## Operation
- Lookup (combinational on PC):
  - idx = PC[IDX_W+1:2]; tag = PC[XLEN-1:IDX_W+2].
  - hit = valid[idx] && tag match.
  - PRED_TAKEN = hit && ctr[idx] >= 2.
  - PRED_NEXT_PC = PRED_TAKEN ? target[idx] : PC+4 (modulo 2^XLEN).
- Resolution:
  - actual = (EX_IS_JUMP || (EX_IS_BRANCH && EX_TAKEN)) ? EX_TARGET : EX_PC+4.
  - redirect = EX_VALID && (actual != EX_PRED_NEXT_PC).
  - FLUSH_IF = FLUSH_ID = redirect (combinational).
- Next PC: redirect ? actual : (STALL ? PC : PRED_NEXT_PC). Redirect has priority over STALL.
- Training, on the edge where EX_VALID && (EX_IS_BRANCH || EX_IS_JUMP), at the entry indexed from EX_PC:
  - Hit, branch: counter +1 if taken, -1 if not, saturating at 0 and 3. Target <= EX_TARGET if taken.
  - Hit, jump: counter <= 3; target <= EX_TARGET.
  - Miss, taken: allocate (valid, tag, target). Counter <= 3 for a jump, 2 for a branch.
  - Miss, not taken: no change.
- Counter states: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.
- STALL never blocks training.

## Timing
- Reset (async assert, sync-to-CLK deassert is the system's job):
  - PC = RESET_VECTOR, PC_VALID = 0, all BTB valid = 0, counters = 0.
  - PRED_TAKEN = 0, PRED_NEXT_PC = RESET_VECTOR+4.
  - FLUSH_* follow inputs; the bench holds EX_VALID = 0 during reset.
- First rising edge after RST_N deasserts: PC_VALID <= 1, PC stays at RESET_VECTOR. Advancing starts on the next edge.
- PC latency: one cycle. A redirect seen in cycle N gives PC = actual in cycle N+1; flushes are asserted in cycle N only.
- Same-index lookup and training in one cycle: the lookup sees the pre-update entry; the new entry is visible the next cycle.
- Reset mid-operation clears all state immediately; a pending redirect is discarded.
- PC wraps from 2^XLEN-4 to 0 with no error.

## Configuration
- PC_STATS_EN defined: adds outputs STAT_RESOLVED and STAT_MISPREDICT, 32 bits each.
  - Each counts edges with a resolved branch/jump and with redirect, respectively.
  - Saturating at all-ones; cleared by RST_N.
- PC_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package pc_pkg:
  - btb_entry_t struct (valid, tag, target, ctr[1:0]).
  - Counter constants CTR_SNT/CTR_WNT/CTR_WT/CTR_ST.
  - Function sat_update(ctr, taken).
- One sub-module: btb_direct_mapped.
  - Contents: storage, lookup, training.
  - Parameters: XLEN, BTB_DEPTH.
  - The top keeps the PC register, redirect logic and statistics.

## Test plan
- Reset, RESET_VECTOR = 32'h100: PC = 0x100 and PC_VALID = 0 during reset. PC_VALID = 1 after the first edge, then PC sequence 0x100, 0x104, 0x108.
- Taken branch at 0x108, target 0x200, BTB cold: redirect to 0x200 with FLUSH_IF = FLUSH_ID = 1 for one cycle. Next fetch of 0x108 gives PRED_TAKEN = 1 and PRED_NEXT_PC = 0x200.
- Same branch resolved not-taken twice: counter goes 2, 1, 0. Afterwards PRED_NEXT_PC = 0x10C, and each not-taken resolution is checked for redirect.
- STALL = 1 for 3 cycles with no redirect: PC holds. STALL = 1 together with a redirect to 0x300: PC = 0x300 next cycle.
- JAL at 0x40 to 0x80, then 0x48 (same index when BTB_DEPTH = 2) taken to 0xC0: the second allocation evicts the first. Refetching 0x40 misses.
- With PC_STATS_EN: 5 resolutions including 2 mispredicts give STAT_RESOLVED = 5 and STAT_MISPREDICT = 2. Asserting RST_N low mid-run clears both to 0.
